// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, funct codes, ALU operations and reset/base defaults
package mips_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0040_0000;
  localparam logic [31:0] DRAM_BASE_DEFAULT = 32'h1001_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {WD_ALU, WD_MEM, WD_LINK} wd_sel_e;

  // Shifts operate on b (rt) by sh; lui places b[15:0] in the upper half.
  function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] y;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_SLL:  y = b << sh;
      ALU_SRL:  y = b >> sh;
      ALU_SRA:  y = $unsigned($signed(b) >>> sh);
      ALU_LUI:  y = {b[15:0], 16'h0000};
      default:  y = 32'h0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - 32x32 register file, two combinational reads, one write, async clear
module cpu_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] array_reg [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) array_reg[i] <= 32'h0;
    end else if (we && (wa != 5'd0)) begin
      array_reg[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : array_reg[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : array_reg[ra2];

endmodule

// File: rtl/dram.sv
// rtl/dram.sv - data word memory, combinational read and rising-edge write
module dram #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h1001_0000
) (
  input  logic        clk,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   data_array [DEPTH];
  logic [AW-1:0] idx;

  // Byte offset bits are dropped; out-of-range addresses wrap.
  assign idx   = AW'((addr - BASE) >> 2);
  assign rdata = data_array[idx];

  always_ff @(posedge clk) begin
    if (we) data_array[idx] <= wdata;
  end

endmodule

// File: rtl/iram.sv
// rtl/iram.sv - instruction word memory indexed by byte address relative to the text base
module iram #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h0040_0000
) (
  input  logic        clk,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   inst_array [DEPTH];
  logic [AW-1:0] idx;

  // Out-of-range addresses wrap onto the array.
  assign idx   = AW'((addr - BASE) >> 2);
  assign rdata = inst_array[idx];

  always_ff @(posedge clk) begin
    if (we) inst_array[idx] <= wdata;
  end

endmodule

// File: rtl/sccpu.sv
// rtl/sccpu.sv - single-cycle core: decode, ALU, next-PC and register file
module sccpu
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, pc_plus4, sext_imm, zext_imm, br_target, j_target;
  logic [31:0] alu_a, alu_b, alu_y, wd, npc;
  logic [4:0]  alu_sh, wa;
  logic        reg_we;
  alu_op_e     alu_op;
  wd_sel_e     wd_sel;

  assign opcode    = inst[31:26];
  assign rs        = inst[25:21];
  assign rt        = inst[20:16];
  assign rd        = inst[15:11];
  assign shamt     = inst[10:6];
  assign funct     = inst[5:0];
  assign imm       = inst[15:0];
  assign sext_imm  = {{16{imm[15]}}, imm};
  assign zext_imm  = {16'h0000, imm};
  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], inst[25:0], 2'b00};

  cpu_regfile cpu_ref (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs),
    .ra2   (rt),
    .we    (reg_we),
    .wa    (wa),
    .wd    (wd),
    .rd1   (rs_val),
    .rd2   (rt_val)
  );

  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = rs_val;
    alu_b  = rt_val;
    alu_sh = shamt;
    reg_we = 1'b0;
    wa     = rd;
    wd_sel = WD_ALU;
    mem_we = 1'b0;
    npc    = pc_plus4;
    case (opcode)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_SLLV: begin alu_op = ALU_SLL; alu_sh = rs_val[4:0]; end
          FN_SRLV: begin alu_op = ALU_SRL; alu_sh = rs_val[4:0]; end
          FN_SRAV: begin alu_op = ALU_SRA; alu_sh = rs_val[4:0]; end
          FN_JR:   begin reg_we = 1'b0; npc = rs_val; end
          FN_JALR: begin wd_sel = WD_LINK; npc = rs_val; end
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin reg_we = 1'b1; wa = rt; alu_b = sext_imm; end
      OP_SLTI:  begin reg_we = 1'b1; wa = rt; alu_b = sext_imm; alu_op = ALU_SLT; end
      OP_SLTIU: begin reg_we = 1'b1; wa = rt; alu_b = sext_imm; alu_op = ALU_SLTU; end
      OP_ANDI:  begin reg_we = 1'b1; wa = rt; alu_b = zext_imm; alu_op = ALU_AND; end
      OP_ORI:   begin reg_we = 1'b1; wa = rt; alu_b = zext_imm; alu_op = ALU_OR; end
      OP_XORI:  begin reg_we = 1'b1; wa = rt; alu_b = zext_imm; alu_op = ALU_XOR; end
      OP_LUI:   begin reg_we = 1'b1; wa = rt; alu_b = zext_imm; alu_op = ALU_LUI; end
      OP_LW:    begin reg_we = 1'b1; wa = rt; alu_b = sext_imm; wd_sel = WD_MEM; end
      OP_SW:    begin mem_we = 1'b1; alu_b = sext_imm; end
      OP_BEQ:   if (rs_val == rt_val) npc = br_target;
      OP_BNE:   if (rs_val != rt_val) npc = br_target;
      OP_J:     npc = j_target;
      OP_JAL:   begin reg_we = 1'b1; wa = 5'd31; wd_sel = WD_LINK; npc = j_target; end
      default:  ;
    endcase
  end

  assign alu_y     = alu_calc(alu_op, alu_a, alu_b, alu_sh);
  assign mem_addr  = alu_y;
  assign mem_wdata = rt_val;

  always_comb begin
    case (wd_sel)
      WD_MEM:  wd = mem_rdata;
      WD_LINK: wd = pc_plus4;
      default: wd = alu_y;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= PC_RESET;
    else        pc <= npc;
  end

endmodule

// File: rtl/mips_sccomp_soc.sv
// rtl/mips_sccomp_soc.sv - single-cycle MIPS32 subset computer: core, IRAM and DRAM
module mips_sccomp_soc
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT,
  parameter logic [31:0] DRAM_BASE  = DRAM_BASE_DEFAULT,
  parameter int          IRAM_DEPTH = 1024,
  parameter int          DRAM_DEPTH = 1024
) (
  input  logic        clk_in,
  input  logic        reset,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  // IRAM is loaded only through the backdoor; its write port stays idle.
  iram #(.DEPTH(IRAM_DEPTH), .BASE(PC_RESET)) iram_inst (
    .clk   (clk_in),
    .addr  (pc),
    .we    (1'b0),
    .wdata (32'h0),
    .rdata (inst)
  );

  dram #(.DEPTH(DRAM_DEPTH), .BASE(DRAM_BASE)) dram_inst (
    .clk   (clk_in),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  sccpu #(.PC_RESET(PC_RESET)) sccpu (
    .clk       (clk_in),
    .rst_n     (reset),
    .inst      (inst),
    .mem_rdata (mem_rdata),
    .pc        (pc),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

endmodule

// File: tb/tb_mips_sccomp_soc.sv
// tb/tb_mips_sccomp_soc.sv - self-checking bench: vector table, random ALU ops, program sequences
module tb_mips_sccomp_soc;

  localparam logic [31:0] PCR = 32'h0040_0000;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] inst, pc;
  int passed = 0;
  int total  = 0;

  mips_sccomp_soc dut (.clk_in(clk_in), .reset(reset), .inst(inst), .pc(pc));

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r3;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic logic [31:0] rty(input int rs, input int rt, input int rd,
                                      input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] ity(input logic [5:0] op, input int rs, input int rt,
                                      input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] jty(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic logic [31:0] reg_of(input int r);
    return dut.sccpu.cpu_ref.array_reg[r];
  endfunction

  function automatic int nonzero_regs();
    int n = 0;
    for (int i = 0; i < 32; i++) if (dut.sccpu.cpu_ref.array_reg[i] != 32'h0) n++;
    return n;
  endfunction

  // Reference result for rd/rt = op(rs=a, rt=b) written from the instruction set rules.
  function automatic logic [31:0] model(input logic [31:0] i, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [5:0]  op = i[31:26];
    logic [5:0]  fn = i[5:0];
    logic [31:0] se = {{16{i[15]}}, i[15:0]};
    logic [31:0] ze = {16'h0, i[15:0]};
    int          sh = int'(i[10:6]);
    int          vs = int'(a % 32);
    logic signed [31:0] sb = b;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: return a + b;
        6'h22, 6'h23: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h26: return a ^ b;
        6'h27: return ~(a | b);
        6'h2a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2b: return (a < b) ? 32'd1 : 32'd0;
        6'h00: return b << sh;
        6'h02: return b >> sh;
        6'h03: return sb >>> sh;
        6'h04: return b << vs;
        6'h06: return b >> vs;
        6'h07: return sb >>> vs;
        default: return 32'h0;
      endcase
    end
    case (op)
      6'h08, 6'h09: return a + se;
      6'h0a: return ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
      6'h0b: return (a < se) ? 32'd1 : 32'd0;
      6'h0c: return a & ze;
      6'h0d: return a | ze;
      6'h0e: return a ^ ze;
      6'h0f: return {i[15:0], 16'h0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic load(input logic [31:0] prog[$]);
    @(negedge clk_in);
    for (int i = 0; i < prog.size(); i++) dut.iram_inst.inst_array[i] <= prog[i];
    dut.iram_inst.inst_array[prog.size()] <= 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic load_imm(inout logic [31:0] prog[$], input int r, input logic [31:0] v);
    prog.push_back(ity(6'h0f, 0, r, v[31:16]));
    prog.push_back(ity(6'h0d, r, r, v[15:0]));
  endtask

  // $1=a, $2=b via lui/ori, then the instruction under test at PCR+0x10.
  task automatic run_vec(input vec_t v);
    logic [31:0] prog[$];
    load_imm(prog, 1, v.a);
    load_imm(prog, 2, v.b);
    prog.push_back(v.instr);
    load(prog);
    do_reset();
    step(5);
    check({v.name, " r3"}, reg_of(3), v.exp_r3);
    check({v.name, " pc"}, pc, v.exp_pc);
  endtask

  initial begin
    vec_t        vt[$];
    logic [31:0] p2[$], p3[$], p4[$], p5[$];
    logic [5:0]  rfn[16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0]  iop[8]  = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    localparam logic [31:0] NX = PCR + 32'h14;

    vt.push_back('{"add",   rty(1,2,3,0,6'h20), 32'd5, 32'd7, 32'd12, NX});
    vt.push_back('{"sub",   rty(1,2,3,0,6'h22), 32'd5, 32'd7, 32'hFFFF_FFFE, NX});
    vt.push_back('{"nor",   rty(1,2,3,0,6'h27), 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, NX});
    vt.push_back('{"slt",   rty(1,2,3,0,6'h2a), 32'hFFFF_FFFF, 32'd1, 32'd1, NX});
    vt.push_back('{"sltu",  rty(1,2,3,0,6'h2b), 32'hFFFF_FFFF, 32'd1, 32'd0, NX});
    vt.push_back('{"sra",   rty(0,2,3,4,6'h03), 32'd0, 32'h8000_0000, 32'hF800_0000, NX});
    vt.push_back('{"srlv",  rty(1,2,3,0,6'h06), 32'd36, 32'h0000_00F0, 32'h0000_000F, NX});
    vt.push_back('{"sllv",  rty(1,2,3,0,6'h04), 32'd33, 32'd3, 32'd6, NX});
    vt.push_back('{"andi",  ity(6'h0c,1,3,16'h8F0F), 32'hFFFF_1234, 32'd0, 32'h0000_0204, NX});
    vt.push_back('{"xori",  ity(6'h0e,1,3,16'h00FF), 32'hFFFF_0000, 32'd0, 32'hFFFF_00FF, NX});
    vt.push_back('{"slti",  ity(6'h0a,1,3,16'hFFFF), 32'd5, 32'd0, 32'd0, NX});
    vt.push_back('{"sltiu", ity(6'h0b,1,3,16'hFFFF), 32'd5, 32'd0, 32'd1, NX});
    vt.push_back('{"beq_t", ity(6'h04,1,2,16'h0002), 32'd9, 32'd9, 32'd0, PCR + 32'h1C});
    vt.push_back('{"bne_n", ity(6'h05,1,2,16'h0002), 32'd9, 32'd9, 32'd0, NX});
    vt.push_back('{"bne_t", ity(6'h05,1,2,16'h0002), 32'd1, 32'd2, 32'd0, PCR + 32'h1C});
    vt.push_back('{"j",     jty(6'h02, 26'h010_0040), 32'd0, 32'd0, 32'd0, 32'h0040_0100});
    vt.push_back('{"jr",    rty(1,0,0,0,6'h08), 32'h0040_0200, 32'd0, 32'd0, 32'h0040_0200});
    vt.push_back('{"jalr",  rty(1,0,3,0,6'h09), 32'h0040_0300, 32'd0, NX, 32'h0040_0300});
    vt.push_back('{"badop", ity(6'h3f,1,3,16'h1234), 32'd1, 32'd0, 32'd0, NX});
    vt.push_back('{"badfn", rty(1,2,3,0,6'h3f), 32'd1, 32'd2, 32'd0, NX});

    p2.push_back(ity(6'h08, 0, 1, 16'hFFFB));
    p2.push_back(ity(6'h09, 0, 2, 16'h0007));
    p2.push_back(rty(1, 2, 3, 0, 6'h21));
    p2.push_back(rty(1, 2, 4, 0, 6'h2a));
    p2.push_back(rty(1, 2, 5, 0, 6'h2b));
    p2.push_back(ity(6'h0f, 0, 6, 16'h1234));
    p2.push_back(ity(6'h0d, 6, 6, 16'hFFFF));

    // Reset behaviour
    load(p2);
    do_reset();
    step(3);
    @(negedge clk_in);
    reset = 1'b0;
    #1;
    check("rst pc", pc, PCR);
    check("rst regs nonzero", 32'(nonzero_regs()), 32'd0);
    check("rst inst", inst, p2[0]);
    @(negedge clk_in);
    reset = 1'b1;
    step(1);
    check("rst first edge pc", pc, PCR + 32'd4);

    foreach (vt[k]) run_vec(vt[k]);

    for (int k = 0; k < 40; k++) begin
      vec_t v;
      v.a = $urandom();
      v.b = $urandom();
      if ($urandom_range(1) == 1)
        v.instr = rty(1, 2, 3, int'($urandom_range(31)), rfn[$urandom_range(15)]);
      else
        v.instr = ity(iop[$urandom_range(7)], 1, 3, 16'($urandom()));
      v.exp_r3 = model(v.instr, v.a, v.b);
      v.exp_pc = NX;
      v.name   = $sformatf("rand%0d", k);
      run_vec(v);
    end

    // ALU program
    load(p2);
    do_reset();
    step(7);
    check("alu $1", reg_of(1), 32'hFFFF_FFFB);
    check("alu $3", reg_of(3), 32'd2);
    check("alu $4", reg_of(4), 32'd1);
    check("alu $5", reg_of(5), 32'd0);
    check("alu $6", reg_of(6), 32'h1234_FFFF);
    check("alu pc", pc, PCR + 32'h1C);

    // Memory program
    p3.push_back(ity(6'h08, 0, 2, 16'h0055));
    p3.push_back(ity(6'h0f, 0, 1, 16'h1001));
    p3.push_back(ity(6'h2b, 1, 2, 16'h0008));
    p3.push_back(ity(6'h23, 1, 3, 16'h0008));
    p3.push_back(ity(6'h23, 1, 4, 16'h0000));
    p3.push_back(ity(6'h23, 1, 5, 16'h000B));
    load(p3);
    dut.dram_inst.data_array[0] <= 32'hDEAD_BEEF;
    do_reset();
    step(6);
    check("mem dram[2]", dut.dram_inst.data_array[2], 32'h55);
    check("mem lw $3", reg_of(3), 32'h55);
    check("mem lw $4", reg_of(4), 32'hDEAD_BEEF);
    check("mem lw low bits $5", reg_of(5), 32'h55);

    // Reset mid-program keeps DRAM
    load(p2);
    do_reset();
    step(4);
    reset = 1'b0;
    #1;
    check("mid rst pc", pc, PCR);
    check("mid rst regs nonzero", 32'(nonzero_regs()), 32'd0);
    check("mid rst dram[2]", dut.dram_inst.data_array[2], 32'h55);
    check("mid rst dram[0]", dut.dram_inst.data_array[0], 32'hDEAD_BEEF);
    @(negedge clk_in);
    reset = 1'b1;

    // Control flow: beq skip, bne fall-through, jal/jr round trip
    p4.push_back(ity(6'h08, 0, 1, 16'h0001));
    p4.push_back(ity(6'h04, 1, 1, 16'h0002));
    p4.push_back(ity(6'h08, 0, 2, 16'h0007));
    p4.push_back(ity(6'h08, 0, 2, 16'h0008));
    p4.push_back(ity(6'h05, 1, 1, 16'h0005));
    p4.push_back(jty(6'h03, 26'h010_0008));
    p4.push_back(ity(6'h08, 0, 3, 16'h0003));
    p4.push_back(jty(6'h02, 26'h010_0007));
    p4.push_back(ity(6'h08, 0, 4, 16'h0004));
    p4.push_back(rty(31, 0, 0, 0, 6'h08));
    load(p4);
    do_reset();
    step(2);
    check("cf beq pc", pc, PCR + 32'h10);
    step(1);
    check("cf bne pc", pc, PCR + 32'h14);
    step(1);
    check("cf jal pc", pc, PCR + 32'h20);
    check("cf jal $31", reg_of(31), PCR + 32'h18);
    step(2);
    check("cf jr pc", pc, PCR + 32'h18);
    step(1);
    check("cf $2 skipped", reg_of(2), 32'd0);
    check("cf $3", reg_of(3), 32'd3);
    check("cf $4", reg_of(4), 32'd4);
    step(2);
    check("cf j self pc", pc, PCR + 32'h1C);

    // Register 0 discards writes
    p5.push_back(ity(6'h08, 0, 0, 16'h0009));
    p5.push_back(ity(6'h08, 0, 5, 16'h0001));
    p5.push_back(rty(0, 5, 6, 0, 6'h20));
    load(p5);
    do_reset();
    step(3);
    check("zero array_reg[0]", reg_of(0), 32'd0);
    check("zero add $6", reg_of(6), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
